// File: rtl/err_event_ctr_pkg.sv
// Shared types and helpers for the per-channel error event counter.
// Holds the channel FSM state encoding and the counter saturation value helper.
package err_event_ctr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HELD  = 2'd2,
        ST_REARM = 2'd3
    } ch_state_e;

    // All-ones value of a counter of the given width (1..32), returned in 32 bits.
    function automatic logic [31:0] cnt_max(input int width);
        if (width >= 32)
            return 32'hFFFF_FFFF;
        else
            return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/err_event_ch.sv
// One error channel: edge-qualifying FSM with low-sample holdoff, saturating
// event counter, saturation flag and (with ERR_EVENT_CTR_IRQ_EN) sticky irq.
//
// Handshake: none; err_in is a level, incr_pulse is a single-cycle registered
// strobe raised the cycle after err_in is first sampled high in ST_IDLE.
module err_event_ch
    import err_event_ctr_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 2
`ifdef ERR_EVENT_CTR_IRQ_EN
    ,
    parameter int THRESH  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             err_in,
    input  logic             clr,
    output logic             incr_pulse,
    output logic [CNT_W-1:0] cnt,
`ifdef ERR_EVENT_CTR_IRQ_EN
    output logic             irq,
`endif
    output logic             sat
);

    localparam logic [31:0]      CNT_MAX32 = cnt_max(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX32[CNT_W-1:0];
    // The low sample that leaves PULSE/HELD is itself the first holdoff sample,
    // so with HOLDOFF of 0 or 1 that sample already completes the holdoff.
    localparam ch_state_e        LOW_EXIT  = (HOLDOFF > 1) ? ST_REARM : ST_IDLE;
    localparam logic [7:0]       HOLD_LAST = 8'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    ch_state_e        state;
    logic [7:0]       hold_cnt;
    logic             evt;
    logic [CNT_W-1:0] cnt_nxt;

    assign evt = (state == ST_IDLE) && err_in;

    // Next counter value: clear takes priority but never drops a same-edge event.
    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = evt ? CNT_W'(1) : '0;
        else if (evt && (cnt != CNT_MAX))
            cnt_nxt = cnt + 1'b1;
    end

    // Channel FSM with holdoff counter and registered event pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= 8'd0;
            incr_pulse <= 1'b0;
        end else begin
            incr_pulse <= evt;
            case (state)
                ST_IDLE: begin
                    if (err_in)
                        state <= ST_PULSE;
                end
                ST_PULSE, ST_HELD: begin
                    if (err_in) begin
                        state <= ST_HELD;
                    end else begin
                        state    <= LOW_EXIT;
                        hold_cnt <= 8'd1;
                    end
                end
                ST_REARM: begin
                    if (err_in) begin
                        state    <= ST_HELD;
                        hold_cnt <= 8'd0;
                    end else if (hold_cnt >= HOLD_LAST) begin
                        state    <= ST_IDLE;
                        hold_cnt <= 8'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating counter and its registered saturation flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= (cnt_nxt == CNT_MAX);
        end
    end

`ifdef ERR_EVENT_CTR_IRQ_EN
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    // Sticky threshold interrupt; clear beats a same-edge set.
    always_ff @(posedge clk) begin
        if (!rst_n)
            irq <= 1'b0;
        else if (clr)
            irq <= 1'b0;
        else if (evt && (cnt_nxt == THRESH_C))
            irq <= 1'b1;
    end
`else
    // No threshold interrupt in this build.
`endif

endmodule

// File: rtl/err_event_ctr.sv
// Multi-channel error event counter: NUM_CH independent err_event_ch channels
// plus a registered readout mux (one cycle latency, 0 for unused selects).
// Optional feature macro: ERR_EVENT_CTR_IRQ_EN adds THRESH and the irq output.
module err_event_ctr
    import err_event_ctr_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 2,
`ifdef ERR_EVENT_CTR_IRQ_EN
    parameter int THRESH  = 16,
`endif
    parameter int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] err_in,
    input  logic [NUM_CH-1:0] clr,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [NUM_CH-1:0] incr_pulse,
    output logic [CNT_W-1:0]  rd_cnt,
`ifdef ERR_EVENT_CTR_IRQ_EN
    output logic [NUM_CH-1:0] irq,
`endif
    output logic [NUM_CH-1:0] sat
);

    logic [CNT_W-1:0] cnt_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        err_event_ch #(
            .CNT_W   (CNT_W),
`ifdef ERR_EVENT_CTR_IRQ_EN
            .THRESH  (THRESH),
`endif
            .HOLDOFF (HOLDOFF)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .err_in     (err_in[g]),
            .clr        (clr[g]),
            .incr_pulse (incr_pulse[g]),
            .cnt        (cnt_arr[g]),
`ifdef ERR_EVENT_CTR_IRQ_EN
            .irq        (irq[g]),
`endif
            .sat        (sat[g])
        );
    end

    // Registered readout of the selected channel counter.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_cnt <= '0;
        else if (32'(rd_sel) < NUM_CH)
            rd_cnt <= cnt_arr[rd_sel];
        else
            rd_cnt <= '0;
    end

endmodule

// File: tb/tb_err_event_ctr.sv
// Directed bench for err_event_ctr with NUM_CH=4, CNT_W=4, HOLDOFF=2
// (THRESH=3 when ERR_EVENT_CTR_IRQ_EN is defined).
module tb_err_event_ctr;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 4;
    localparam int HOLDOFF = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] err_in;
    logic [NUM_CH-1:0] clr;
    logic [1:0]        rd_sel;
    logic [NUM_CH-1:0] incr_pulse;
    logic [CNT_W-1:0]  rd_cnt;
    logic [NUM_CH-1:0] sat;
`ifdef ERR_EVENT_CTR_IRQ_EN
    logic [NUM_CH-1:0] irq;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    // clock / reset block
    always #5 clk = ~clk;

    err_event_ctr #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
`ifdef ERR_EVENT_CTR_IRQ_EN
        .THRESH  (3),
`endif
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .err_in     (err_in),
        .clr        (clr),
        .rd_sel     (rd_sel),
        .incr_pulse (incr_pulse),
        .rd_cnt     (rd_cnt),
`ifdef ERR_EVENT_CTR_IRQ_EN
        .irq        (irq),
`endif
        .sat        (sat)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] err;
        logic [3:0] clr;
        logic [1:0] sel;
        logic [3:0] exp_pulse;
        logic [3:0] exp_sat;
        logic [3:0] exp_rd;
    } vec_t;

    vec_t vq[$];

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver: one clock edge, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic [3:0] e, input logic [3:0] c,
                           input logic [1:0] s, input logic [3:0] p,
                           input logic [3:0] st, input logic [3:0] rd);
        vec_t v;
        v.rst_n = r; v.err = e; v.clr = c; v.sel = s;
        v.exp_pulse = p; v.exp_sat = st; v.exp_rd = rd;
        vq.push_back(v);
    endtask

    initial begin
        int pulses_seen;
        rst_n  = 1'b0;
        err_in = '0;
        clr    = '0;
        rd_sel = '0;

        //       rst err   clr   sel pulse sat   rd
        add_vec(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0);  // reset state
        add_vec(1, 4'h1, 4'h0, 0, 4'h1, 4'h0, 0);  // ch0 3-cycle error: pulse once
        add_vec(1, 4'h1, 4'h0, 0, 4'h0, 4'h0, 1);
        add_vec(1, 4'h1, 4'h0, 0, 4'h0, 4'h0, 1);
        add_vec(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1);
        add_vec(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1);
        add_vec(1, 4'h2, 4'h0, 1, 4'h2, 4'h0, 0);  // ch1 1,0,1 glitch
        add_vec(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 1);
        add_vec(1, 4'h2, 4'h0, 1, 4'h0, 4'h0, 1);  // no pulse after 1 low
        add_vec(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 1);
        add_vec(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 1);
        add_vec(1, 4'h2, 4'h0, 1, 4'h2, 4'h0, 1);  // second pulse after 2 lows
        add_vec(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 2);
        add_vec(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 2);
        add_vec(1, 4'h1, 4'h1, 0, 4'h1, 4'h0, 1);  // clr with event on ch0
        add_vec(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1);  // count is 1, not 2
        add_vec(1, 4'h0, 4'h1, 0, 4'h0, 4'h0, 1);  // plain clr
        add_vec(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0);
        add_vec(1, 4'hF, 4'h0, 1, 4'hF, 4'h0, 2);  // all channels at once
        add_vec(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 3);
        add_vec(1, 4'h0, 4'h0, 2, 4'h0, 4'h0, 1);
        add_vec(1, 4'h0, 4'h0, 3, 4'h0, 4'h0, 1);
        add_vec(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1);

        foreach (vq[i]) begin
            rst_n  = vq[i].rst_n;
            err_in = vq[i].err;
            clr    = vq[i].clr;
            rd_sel = vq[i].sel;
            tick();
            check($sformatf("vec%0d incr_pulse", i), 32'(incr_pulse), 32'(vq[i].exp_pulse));
            check($sformatf("vec%0d sat", i), 32'(sat), 32'(vq[i].exp_sat));
            check($sformatf("vec%0d rd_cnt", i), 32'(rd_cnt), 32'(vq[i].exp_rd));
        end

        // saturation: 17 separated events on ch2
        err_in = '0; clr = '0; rd_sel = 2'd2;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        pulses_seen = 0;
        for (int e = 1; e <= 17; e++) begin
            err_in = 4'h4;
            tick();
            pulses_seen += int'(incr_pulse[2]);
            check($sformatf("sat ev%0d pulse", e), 32'(incr_pulse), 32'h4);
            check($sformatf("sat ev%0d sat2", e), 32'(sat[2]), (e >= 15) ? 32'd1 : 32'd0);
            err_in = '0;
            for (int k = 0; k < 2; k++) begin
                tick();
                pulses_seen += int'(incr_pulse[2]);
            end
        end
        tick();
        tick();
        check("sat rd_cnt", 32'(rd_cnt), 32'd15);
        check("sat pulse count", 32'(pulses_seen), 32'd17);
        check("sat flag held", 32'(sat), 32'h4);

        // reset during PULSE on ch3, error held through release
        rd_sel = 2'd3;
        err_in = 4'h8;
        tick();
        check("rst pre pulse", 32'(incr_pulse), 32'h8);
        rst_n = 1'b0;
        tick();
        check("rst pulse dropped", 32'(incr_pulse), 32'h0);
        check("rst sat", 32'(sat), 32'h0);
        check("rst rd_cnt", 32'(rd_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post-rst new pulse", 32'(incr_pulse), 32'h8);
        tick();
        check("post-rst held", 32'(incr_pulse), 32'h0);
        err_in = '0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            rd_sel = 2'(k);
            tick();
            tick();
            check($sformatf("post-rst count ch%0d", k), 32'(rd_cnt), (k == 3) ? 32'd1 : 32'd0);
        end

`ifdef ERR_EVENT_CTR_IRQ_EN
        // sticky irq at THRESH=3 on ch0, cleared by clr
        rd_sel = 2'd0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            err_in = 4'h1;
            tick();
            check($sformatf("irq ev%0d", e), 32'(irq[0]), (e == 3) ? 32'd1 : 32'd0);
            err_in = '0;
            tick();
            tick();
        end
        tick();
        tick();
        check("irq sticky", 32'(irq), 32'h1);
        clr = 4'h1;
        tick();
        check("irq cleared", 32'(irq), 32'h0);
        clr = '0;
        tick();
        tick();
        check("irq clr count", 32'(rd_cnt), 32'd0);
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/err_event_ctr.md
ERR_EVENT_CTR -- requirements
Module: err_event_ctr

Interface
REQ-001 The parameter NUM_CH SHALL be declared with default 4, meaning the number of independent error channels (1..32).
REQ-002 The parameter CNT_W SHALL be declared with default 8, meaning the width of each per-channel event counter (2..32).
REQ-003 The parameter HOLDOFF SHALL be declared with default 2, meaning the number of consecutive low samples of err_in[i] required before channel i re-arms (0..255).
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The port clk SHALL be an input of width 1, and is the single clock; all logic samples on its rising edge.
REQ-006 The port rst_n SHALL be an input of width 1, and is the synchronous active-low reset.
REQ-007 The port err_in SHALL be an input of width NUM_CH, carrying the per-channel level error (for example no_space_err).
REQ-008 The port clr SHALL be an input of width NUM_CH, carrying the per-channel synchronous counter/flag clear.
REQ-009 The port rd_sel SHALL be an input of width $clog2(NUM_CH) (minimum 1), selecting the channel for readout.
REQ-010 The port incr_pulse SHALL be an output of width NUM_CH, carrying the per-channel one-cycle event pulse (for example no_space_ctr_incr).
REQ-011 The port rd_cnt SHALL be an output of width CNT_W, carrying the registered count of the selected channel.
REQ-012 The port sat SHALL be an output of width NUM_CH, flagging that a channel counter equals 2^CNT_W-1.

Function
REQ-013 Each channel SHALL run a 4-state FSM: IDLE, PULSE, HELD, REARM.
REQ-014 The FSM SHALL move from IDLE to PULSE when err_in[i] is sampled 1; incr_pulse[i] is registered, high exactly the cycle after that sample, and low in every other state.
REQ-015 From PULSE, the FSM SHALL go to HELD if err_in[i]=1, else to REARM (HOLDOFF>0) or IDLE (HOLDOFF=0).
REQ-016 HELD SHALL stay while err_in[i]=1; on err_in[i]=0 it goes to REARM (HOLDOFF>0) or IDLE (HOLDOFF=0), with no pulse.
REQ-017 REARM SHALL count consecutive low samples; on the HOLDOFF-th low sample it goes to IDLE; any high sample returns it to HELD with no pulse and resets the holdoff count.
REQ-018 Consequently, one error assertion SHALL produce exactly one incr_pulse[i], regardless of its duration or of glitches shorter than HOLDOFF low cycles.
REQ-019 The counter SHALL increment on the same edge that raises incr_pulse[i], and SHALL saturate at 2^CNT_W-1 without wrapping; pulses continue while saturated.
REQ-020 sat[i] SHALL be a registered flag, high whenever count[i]==2^CNT_W-1.
REQ-021 clr[i] SHALL set count[i] to 0 at the next edge; clr[i] together with an increment on the same edge SHALL give count[i]=1 (no lost event); clr SHALL not affect the FSM or incr_pulse.
REQ-022 rd_cnt SHALL equal count[rd_sel] as sampled at the previous edge (1-cycle latency); an rd_sel value >= NUM_CH SHALL return 0.
REQ-023 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be counted.

Reset
REQ-024 While rst_n=0 at an edge, the block SHALL force all FSMs to IDLE and all holdoff counts, counters, incr_pulse, sat, rd_cnt (and irq) to 0.
REQ-025 A reset asserted during PULSE SHALL drop the pulse at that edge.
REQ-026 If err_in[i] is already high at the first edge after rst_n rises, it SHALL be treated as a new event (pulse plus count).

Configuration
REQ-027 When ERR_EVENT_CTR_IRQ_EN is defined, the block SHALL add the parameter THRESH (default 16) and an output irq of width NUM_CH.
REQ-028 With ERR_EVENT_CTR_IRQ_EN defined, irq[i] SHALL set on the edge where count[i] becomes THRESH, stay set (sticky) until clr[i], with clr winning over set on the same edge.
REQ-029 Without ERR_EVENT_CTR_IRQ_EN, the irq port, the THRESH parameter and the associated logic SHALL be absent.

Structure
REQ-030 The package err_event_ctr_pkg SHALL hold the FSM state enum typedef and the counter-max helper function.
REQ-031 The sub-module err_event_ch SHALL implement one channel (FSM, holdoff count, counter, sat, irq) and be generated NUM_CH times; the top level holds only the readout mux and register.

Verification (NUM_CH=4, CNT_W=4, HOLDOFF=2)
REQ-032 err_in[0] high for 3 cycles -> incr_pulse[0] high for exactly 1 cycle, one cycle after the first sample; rd_cnt(sel 0)=1.
REQ-033 err_in[1] as 1,0,1 then 0,0,1 -> first pulse only, then no pulse for the 1-low glitch, then a second pulse after 2 lows; count=2.
REQ-034 17 separated events on channel 2 -> count=15, sat[2]=1 after the 15th event, 17 pulses seen.
REQ-035 clr[0] on the same edge as a new channel-0 event -> count[0]=1.
REQ-036 rst_n=0 during PULSE on channel 3 -> incr_pulse[3]=0 at that edge, all counts 0; err_in[3] held high through release -> one new pulse, count=1.
REQ-037 With ERR_EVENT_CTR_IRQ_EN defined and THRESH=3: third event -> irq[0]=1 and held; clr[0] -> irq[0]=0 and count=0.
